// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM state type and opcode classification for alu_seq.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOTA = 4'b0101;
  localparam logic [3:0] OP_NOTB = 4'b0110;
  localparam logic [3:0] OP_GT   = 4'b0111;
  localparam logic [3:0] OP_LT   = 4'b1000;
  localparam logic [3:0] OP_SHRA = 4'b1001;
  localparam logic [3:0] OP_SHRB = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_NAND = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add multiply (mode=0) or restoring divide (mode=1),
// one bit per cycle; done marks the cycle whose step completes the operation.
module alu_seq_iter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          mode_q, mode_d;

  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic          div_ge;
  logic [W-1:0]  div_diff;
  logic [W-1:0]  hi_step, lo_step;

  // hi holds the running upper product half (MUL) or the partial remainder (DIV);
  // lo holds the shifting multiplier (MUL) or the dividend/quotient bits (DIV).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[W-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[W-1:0] - b_q;
    if (mode_q) begin
      hi_step = div_ge ? div_diff : div_shift[W-1:0];
      lo_step = {lo_q[W-2:0], div_ge};
    end else begin
      hi_step = mul_sum[W:1];
      lo_step = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    mode_d = mode_q;
    if (start) begin
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
      cnt_d  = CW'(W - 1);
      busy_d = 1'b1;
      mode_d = mode;
    end else if (busy_q) begin
      hi_d = hi_step;
      lo_d = lo_step;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      mode_q <= mode_d;
    end
  end

  assign done   = busy_q && (cnt_q == '0);
  assign result = lo_step;
  assign ovf    = !mode_q && (hi_step != '0);

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready input and iterative MUL/DIV.
// Optional flag outputs (zero/neg/ovf) are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   s,
  output logic [W-1:0] yout,
  output logic         carry,
  output logic         dbz,
`ifdef ALU_SEQ_FLAGS_EN
  output logic         zero,
  output logic         neg,
  output logic         ovf,
`endif
  output logic         out_valid
);

  state_t state_q, state_d;

  logic         accept, div0, start;
  logic         iter_done, iter_ovf;
  logic [W-1:0] iter_result;
  logic [W:0]   add_full, sub_full;
  logic [W-1:0] sc_y;
  logic         sc_c;
  logic [W-1:0] yout_q, yout_d;
  logic         carry_q, carry_d;
  logic         dbz_q, dbz_d;

  assign accept = in_valid && in_ready;
  assign div0   = (s == OP_DIV) && (b == '0);
  assign start  = accept && is_multicycle(s) && !div0;

  alu_seq_iter #(.W(W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (s == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .result (iter_result),
    .ovf    (iter_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = start ? ST_ITER : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_ITER:  if (iter_done) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state_q != ST_ITER);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    sc_y     = '0;
    sc_c     = 1'b0;
    case (s)
      OP_ADD:  begin sc_y = add_full[W-1:0]; sc_c = add_full[W]; end
      OP_SUB:  begin sc_y = sub_full[W-1:0]; sc_c = sub_full[W]; end
      OP_OR:   sc_y = a | b;
      OP_AND:  sc_y = a & b;
      OP_XOR:  sc_y = a ^ b;
      OP_NOTA: sc_y = ~a;
      OP_NOTB: sc_y = ~b;
      OP_GT:   sc_y = W'(a > b);
      OP_LT:   sc_y = W'(a < b);
      OP_SHRA: begin sc_y = a >> 1; sc_c = a[0]; end
      OP_SHRB: begin sc_y = b >> 1; sc_c = b[0]; end
      OP_NOR:  sc_y = ~(a | b);
      OP_XNOR: sc_y = ~(a ^ b);
      OP_NAND: sc_y = ~(a & b);
      default: sc_y = '0;
    endcase
  end

  always_comb begin
    yout_d  = yout_q;
    carry_d = carry_q;
    dbz_d   = dbz_q;
    if (iter_done) begin
      yout_d  = iter_result;
      carry_d = iter_ovf;
      dbz_d   = 1'b0;
    end else if (accept && !start) begin
      yout_d  = div0 ? '0 : sc_y;
      carry_d = div0 ? 1'b0 : sc_c;
      dbz_d   = div0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      yout_q  <= '0;
      carry_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      yout_q  <= yout_d;
      carry_q <= carry_d;
      dbz_q   <= dbz_d;
    end
  end

  assign yout  = yout_q;
  assign carry = carry_q;
  assign dbz   = dbz_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    if (iter_done || (accept && !start)) begin
      zero_d = (yout_d == '0);
      neg_d  = yout_d[W-1];
      ovf_d  = 1'b0;
      if (iter_done)
        ovf_d = iter_ovf;
      else if (s == OP_ADD)
        ovf_d = (a[W-1] == b[W-1]) && (add_full[W-1] != a[W-1]);
      else if (s == OP_SUB)
        ovf_d = (a[W-1] != b[W-1]) && (sub_full[W-1] != a[W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 16-bit combinational CLA ALU. It keeps the same 4-bit opcode map.
- It adds a valid/ready input handshake and registered outputs.
- MUL and DIV are iterative (shift-add and restoring divide) instead of combinational `*` and `/`.
- It sits between the operand register file and the writeback stage. It is the integer execute unit of the datapath.

Parameters:
- W, 16, operand/result width; legal range 4..64.
- CW, $clog2(W)+1, iteration counter width (localparam, derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  W  operand A
- b  input  W  operand B
- s  input  4  opcode
- yout  output  W  registered result
- carry  output  1  registered carry/aux bit
- dbz  output  1  divide-by-zero flag, valid with out_valid
- out_valid  output  1  one-cycle pulse; yout/carry/dbz valid

Behaviour:
- Reset: all outputs and registers are 0, state IDLE. in_ready=1 in the cycle after rst deasserts. While rst=1, in_ready=0.
- rst during ITER aborts the operation silently. No out_valid is produced.
- States are IDLE, ITER, DONE. in_ready=1 in IDLE and DONE, and 0 in ITER.
- An operation is accepted when in_valid && in_ready. a, b and s are captured on acceptance; later input changes are ignored.
- Single-cycle ops (all except 1011 and 1111): result is registered at acceptance, giving latency 1. Next state is DONE. In DONE, out_valid=1 for exactly one cycle.
- From DONE, state returns to IDLE, or restarts directly if a new op is accepted. Back-to-back single-cycle ops give one result per cycle.
- Opcodes, with carry=0 unless stated:
  - 0000 ADD: carry = bit W of a+b.
  - 0001 SUB: a+~b+1, carry = bit W (1 means no borrow).
  - 0010 OR, 0011 AND, 0100 XOR.
  - 0101 ~a, 0110 ~b.
  - 0111 a>b, 1000 a<b: unsigned compare, result 1 or 0 zero-extended.
  - 1001 a>>1, carry=a[0]. 1010 b>>1, carry=b[0].
  - 1100 NOR, 1101 XNOR, 1110 NAND.
- 1111 MUL: shift-add, one partial product per cycle, W cycles in ITER, out_valid at cycle W+1 after acceptance.
  - yout = low W bits of the product.
  - carry = 1 if the high W bits are non-zero (overflow).
- 1011 DIV: restoring divide, one quotient bit per cycle, W cycles in ITER, same latency as MUL.
  - yout = unsigned quotient, carry=0.
  - b==0 is detected at acceptance and skips ITER: latency 1, yout=0, carry=0, dbz=1.
- dbz=0 for every other result. yout, carry and dbz hold their values until the next result is written.
- The ITER counter counts down from W-1 to 0 with no wrap. Exit to DONE happens when the counter reaches 0.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- When defined, three extra output ports are present: zero (yout==0), neg (yout[W-1]) and ovf.
  - ovf = signed overflow for ADD/SUB, equal to carry for MUL, 0 otherwise.
  - All three are registered alongside yout, reset to 0, and valid with out_valid.
- When not defined, these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD..OP_MUL), with the 4-bit values listed above;
  - a state enum (ST_IDLE, ST_ITER, ST_DONE);
  - an is_multicycle(op) function.
- One sub-module, alu_seq_iter: the shared MUL/DIV datapath.
  - Holds the accumulator/remainder, shifting multiplier/quotient register and counter.
  - Interface: start, mode, a, b, done, result, ovf.
- The top level owns the FSM, the single-cycle ops and the output registers.

Test Plan:
- Reset with in_valid=1 for 3 cycles, then release. Expect no out_valid, outputs 0, in_ready=1 in the first cycle after release.
- W=16, ADD a=FFFF, b=0001. Expect yout=0000, carry=1, out_valid one cycle after acceptance.
- Back-to-back single-cycle ops, SUB 0005-0007 then XOR. Expect yout=FFFE with carry=0, then the XOR result on consecutive cycles.
- MUL 0100*0100. Expect in_ready=0 for 16 cycles, yout=0000, carry=1, out_valid at cycle 17.
- Same MUL sequence with 00FF*0003: yout=02FD, carry=0.
- DIV 0064/0007: yout=000E, latency 17, dbz=0.
- DIV a=1234, b=0: yout=0, dbz=1, latency 1.
- Assert rst at ITER cycle 8 of a DIV. Expect no out_valid, state IDLE, and a new ADD accepted and correct immediately after reset.
